// File: rtl/bcd_pkg.sv
// Shared constants and FSM state encoding for the binary-to-BCD converter.
package bcd_pkg;
    localparam int W          = 20;
    localparam int NDIG       = 6;
    localparam int ACC_DIGITS = 7;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bcd_convert_ctrl.sv
// Sequential 20-bit binary to 6-digit BCD converter using double-dabble.
// Start accepted at edge k gives a one-cycle done pulse after edge k+20.
// Start is ignored while busy; a start during the done cycle begins a new conversion.
module bcd_convert_ctrl
    import bcd_pkg::*;
#(
    parameter int W    = bcd_pkg::W,
    parameter int NDIG = bcd_pkg::NDIG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [3:0]   dres0,
    output logic [3:0]   dres1,
    output logic [3:0]   dres2,
    output logic [3:0]   dres3,
    output logic [3:0]   dres4,
    output logic [3:0]   dres5
);
    localparam int ACC_W = 4 * ACC_DIGITS;
    localparam int RES_W = 4 * NDIG;

    state_t             state;
    state_t             state_nx;
    logic [W-1:0]       sr;
    logic [W-1:0]       sr_nx;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_nx;
    logic [CNT_W-1:0]   cnt;
    logic [RES_W-1:0]   res;
    logic               ovf_q;
    logic               last_iter;

    for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit    (acc[4*g +: 4]),
            .adjusted (acc_adj[4*g +: 4])
        );
    end

    assign {acc_nx, sr_nx} = {acc_adj, sr} << 1;
    assign last_iter       = (cnt == CNT_W'(W - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last_iter) state_nx = DONE;
            DONE:    state_nx = start ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            res   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sr  <= value;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= sr_nx;
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    // Results only move on the final iteration so they hold during SHIFT.
                    if (last_iter) begin
                        res   <= acc_nx[RES_W-1:0];
                        ovf_q <= |acc_nx[ACC_W-1:RES_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);
    assign ovf   = ovf_q;
    assign dres0 = res[3:0];
    assign dres1 = res[7:4];
    assign dres2 = res[11:8];
    assign dres3 = res[15:12];
    assign dres4 = res[19:16];
    assign dres5 = res[23:20];
endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Randomised and directed bench for bcd_convert_ctrl with a cycle-level arithmetic reference model.
module tb_bcd_convert_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] value;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  dres0, dres1, dres2, dres3, dres4, dres5;
    logic [3:0]  d [6];
    logic [23:0] packed_res;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit mvalid = 1'b0;

    // Reference model: remaining iterations, captured operand, last result.
    int m_left = 0;
    int m_val  = 0;
    int m_res  = 0;
    bit m_ovf  = 1'b0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    bcd_convert_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dres0 (dres0),
        .dres1 (dres1),
        .dres2 (dres2),
        .dres3 (dres3),
        .dres4 (dres4),
        .dres5 (dres5)
    );

    assign d[0] = dres0;
    assign d[1] = dres1;
    assign d[2] = dres2;
    assign d[3] = dres3;
    assign d[4] = dres4;
    assign d[5] = dres5;
    assign packed_res = {dres5, dres4, dres3, dres2, dres1, dres0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit done_nx;
        done_nx = 1'b0;
        if (rst) begin
            m_left = 0;
            m_res  = 0;
            m_ovf  = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_res   = m_val % 1000000;
                m_ovf   = (m_val > 999999);
                done_nx = 1'b1;
            end
        end else if (start) begin
            m_val  = value;
            m_left = 20;
        end
        m_done = done_nx;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mvalid) begin
            chk("busy", busy, (m_left > 0));
            chk("done", done, m_done);
            chk("ovf", ovf, m_ovf);
            for (int i = 0; i < 6; i++) begin
                int p;
                p = 1;
                for (int j = 0; j < i; j++) p = p * 10;
                chk($sformatf("dres%0d", i), d[i], (m_res / p) % 10);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one conversion and measure negedges until done and busy cycles seen.
    task automatic convert(input logic [19:0] v, output int lat, output int bz);
        start = 1'b1;
        value = v;
        step();
        start = 1'b0;
        value = 20'($urandom);
        lat = 0;
        bz  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bz++;
            if (done) break;
        end
        chk("latency", lat, 21);
        step();
    endtask

    initial begin
        int lat, bz, base, t0;
        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        step();
        mvalid = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_digits", packed_res, 0);

        // Reset wins over start; start is honoured at the first edge with rst low.
        start = 1'b1;
        value = 20'd9;
        step();
        chk("rst_prio_busy", busy, 0);
        rst = 1'b0;
        start = 1'b0;
        convert(20'd0, lat, bz);
        chk("zero_busy_cycles", bz, 20);
        chk("zero_digits", packed_res, 24'h000000);
        chk("zero_ovf", ovf, 0);

        convert(20'd999999, lat, bz);
        chk("d999999", packed_res, 24'h999999);
        chk("ovf999999", ovf, 0);
        convert(20'd123456, lat, bz);
        chk("d123456", packed_res, 24'h123456);
        convert(20'd1000000, lat, bz);
        chk("d1000000", packed_res, 24'h000000);
        chk("ovf1000000", ovf, 1);
        convert(20'd1048575, lat, bz);
        chk("d1048575", packed_res, 24'h048575);
        chk("ovf1048575", ovf, 1);

        // Start during SHIFT must be ignored.
        base = done_cnt;
        start = 1'b1;
        value = 20'd42;
        step();
        start = 1'b0;
        repeat (5) step();
        start = 1'b1;
        value = 20'd7;
        step();
        start = 1'b0;
        repeat (25) step();
        chk("ignore_pulses", done_cnt - base, 1);
        chk("ignore_res", packed_res, 24'h000042);

        // Back-to-back with start held through DONE.
        start = 1'b1;
        value = 20'd10;
        step();
        t0 = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
        end
        chk("b2b_first_done", done, 1);
        chk("b2b_first_res", packed_res, 24'h000010);
        value = 20'd20;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            t0++;
            if (done) break;
            if (packed_res !== 24'h000010) chk("b2b_hold", packed_res, 24'h000010);
        end
        chk("b2b_spacing", t0, 21);
        chk("b2b_second_res", packed_res, 24'h000020);
        step();

        // Reset mid-conversion aborts without a done pulse.
        base = done_cnt;
        start = 1'b1;
        value = 20'd555555;
        step();
        start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (30) step();
        chk("abort_pulses", done_cnt - base, 0);
        chk("abort_digits", packed_res, 0);
        chk("abort_ovf", ovf, 0);
        convert(20'd1, lat, bz);
        chk("after_abort", packed_res, 24'h000001);

        // Random traffic: starts, operands and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       value = 20'($urandom_range(1000000, 1048575));
                1:       value = 20'($urandom_range(0, 999));
                default: value = 20'($urandom);
            endcase
            step();
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (25) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_convert_ctrl.md
BCD_CONVERT_CTRL -- requirements
Module: bcd_convert_ctrl

Interface
REQ-001 Parameter: W, 20, binary input width in bits; fixed at 20 for this release.
REQ-002 Parameter: NDIG, 6, number of decimal digit outputs.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; there are no other clock or reset inputs.
REQ-004 Port: clk  in  1  rising-edge clock for all state.
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: start  in  1  request to convert `value`; sampled at a rising edge of clk.
REQ-007 Port: value  in  20  unsigned binary operand; sampled only on an accepted start.
REQ-008 Port: busy  out  1  high while a conversion is in progress.
REQ-009 Port: done  out  1  one-cycle pulse; results are valid.
REQ-010 Port: ovf  out  1  high when the last converted value exceeded 999999.
REQ-011 Port: dres0..dres5  out  4 each  BCD digits of the last result; dres0 = units, dres5 = hundred-thousands.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL:
- capture value into a 20-bit shift register;
- clear a 28-bit (7-digit) BCD accumulator;
- clear the iteration counter;
- enter SHIFT.
REQ-014 In SHIFT, each edge SHALL perform one double-dabble iteration: add 3 to every accumulator digit >= 5, then shift {accumulator, shift register} left by 1.
REQ-015 The block SHALL perform exactly W=20 iterations; on the edge of the 20th iteration it SHALL enter DONE.
REQ-016 On the same edge as REQ-015, the block SHALL register:
- dres0..dres5 from the low six accumulator digits of the final iteration;
- ovf = 1 if the seventh digit is nonzero.
REQ-017 Latency: with start accepted at edge k, done SHALL be high during the cycle following edge k+20, for exactly one cycle.
REQ-018 busy SHALL be 1 exactly while in SHIFT and 0 in IDLE and DONE.
REQ-019 start while in SHIFT SHALL be ignored with no effect on the conversion in progress.
REQ-020 start while in DONE SHALL be accepted as in REQ-013, allowing back-to-back conversions; otherwise DONE returns to IDLE.
REQ-021 dres0..dres5 and ovf SHALL hold their values until the next completed conversion; they SHALL NOT change during SHIFT.
REQ-022 For value > 999999, the block SHALL report ovf=1 and the low six decimal digits (value mod 1000000).
REQ-023 Every digit output SHALL always be in the range 0..9.

Reset
REQ-024 When rst=1 at an edge, the block SHALL go to IDLE and clear: busy, done, ovf, dres0..dres5, counter, shift register and accumulator.
REQ-025 rst SHALL take priority over start.
REQ-026 Reset during SHIFT SHALL abort the conversion with no done pulse.
REQ-027 start SHALL be honoured at the first edge with rst=0.

Structure
REQ-028 Package bcd_pkg SHALL hold the constants W=20, NDIG=6 and ACC_DIGITS=7, and the FSM state enum.
REQ-029 Sub-module bcd_add3 (4-bit in and out: add 3 if the input is >= 5) SHALL be instantiated once per accumulator digit (7 instances).
REQ-030 All sequential logic SHALL sit in the top module; the iteration counter SHALL be 5 bits.

Verification
REQ-031 value=0, start at edge k -> done high in the cycle after edge k+20; all digits 0; ovf=0; busy high for exactly 20 cycles.
REQ-032 value=999999 -> dres5..dres0 = 9,9,9,9,9,9; ovf=0. value=123456 -> dres5..dres0 = 1,2,3,4,5,6.
REQ-033 value=1000000 -> all digits 0, ovf=1. value=1048575 -> dres5..dres0 = 0,4,8,5,7,5, ovf=1.
REQ-034 Start with value=42, then start with value=7 during SHIFT -> the second start is ignored; result 42; exactly one done pulse.
REQ-035 value=10 with start held high through DONE, then value=20 presented -> done pulses 21 cycles apart; results 10 then 20; outputs hold 10 until the second completion.
REQ-036 rst at iteration 10 of value=555555 -> no done pulse; all outputs 0; a new start with value=1 completes normally after 20 cycles.
